// File: rtl/ipu_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package ipu_pkg;

    localparam int unsigned ENTRY_XLEN = 32;
    localparam int unsigned PC_INCR    = 4;

    typedef struct packed {
        logic [ENTRY_XLEN-1:0] pc;
        logic [ENTRY_XLEN-1:0] instr;
        logic                  filled;
    } entry_t;

    // Occupancy needs one extra bit so that a full queue is distinct from empty.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ipu_entry_queue.sv
// Prefetch queue storage: in-order allocate, fill and pop with separate pointers.
module ipu_entry_queue
    import ipu_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned OW    = occ_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  alloc,
    input  logic [ENTRY_XLEN-1:0] alloc_pc,
    input  logic                  fill,
    input  logic [ENTRY_XLEN-1:0] fill_data,
    input  logic                  pop,
    output entry_t                head,
    output logic [OW-1:0]         occupancy,
    output logic [OW-1:0]         unfilled
);

    localparam int unsigned PW = $clog2(DEPTH);

    entry_t          entries [DEPTH];
    logic [PW-1:0]   alloc_ptr;
    logic [PW-1:0]   fill_ptr;
    logic [PW-1:0]   head_ptr;
    logic            fill_ok;

    // Responses only ever target the oldest allocated-but-unfilled entry.
    assign fill_ok = fill && (unfilled != '0);
    assign head    = entries[head_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            occupancy <= '0;
            unfilled  <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i].filled <= 1'b0;
            end
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            occupancy <= '0;
            unfilled  <= '0;
        end else begin
            if (alloc) begin
                entries[alloc_ptr].pc     <= alloc_pc;
                entries[alloc_ptr].filled <= 1'b0;
                alloc_ptr                 <= alloc_ptr + 1'b1;
            end
            if (fill_ok) begin
                entries[fill_ptr].instr  <= fill_data;
                entries[fill_ptr].filled <= 1'b1;
                fill_ptr                 <= fill_ptr + 1'b1;
            end
            if (pop) begin
                entries[head_ptr].filled <= 1'b0;
                head_ptr                 <= head_ptr + 1'b1;
            end
            occupancy <= occupancy + OW'(alloc) - OW'(pop);
            unfilled  <= unfilled + OW'(alloc) - OW'(fill_ok);
        end
    end

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: fetch PC, redirect/drop control and the entry queue.
// Define IPU_BRANCH_ADDER_EN to form the redirect target as base + offset.
module instruction_prefetch_unit
    import ipu_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          stall,
    input  logic                          redirect_valid,
`ifdef IPU_BRANCH_ADDER_EN
    input  logic [XLEN-1:0]               redirect_base_pc,
    input  logic [XLEN-1:0]               redirect_offset,
`else
    input  logic [XLEN-1:0]               redirect_target,
`endif
    output logic                          imem_req_valid,
    input  logic                          imem_req_ready,
    output logic [XLEN-1:0]               imem_req_addr,
    input  logic                          imem_rsp_valid,
    input  logic [XLEN-1:0]               imem_rsp_data,
    output logic                          if_valid,
    input  logic                          if_ready,
    output logic [XLEN-1:0]               if_instr,
    output logic [XLEN-1:0]               if_pc,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int unsigned OW = occ_width(DEPTH);

    if (XLEN != ENTRY_XLEN) begin : g_bad_xlen
        $error("instruction_prefetch_unit: XLEN must equal ipu_pkg::ENTRY_XLEN");
    end

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] target;
    logic [OW-1:0]   drop_cnt;
    logic [OW-1:0]   unfilled;
    logic            req_fire;
    logic            fill;
    logic            pop;
    logic            rsp_drop;
    entry_t          head;

`ifdef IPU_BRANCH_ADDER_EN
    assign target = redirect_base_pc + redirect_offset;
`else
    assign target = redirect_target;
`endif

    // Gated by reset_n so the request drops combinationally while reset is held.
    assign imem_req_valid = reset_n && !stall && !redirect_valid
                          && (occupancy < OW'(DEPTH)) && (drop_cnt == '0);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign fill     = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign pop      = if_valid && if_ready && !redirect_valid;

    assign if_valid = head.filled;
    assign if_pc    = head.pc;
    assign if_instr = head.instr;

    // On redirect, every unanswered request (older drops included) must be
    // discarded, minus the response landing in the redirect cycle itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= target;
            drop_cnt <= drop_cnt + unfilled - OW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(PC_INCR);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    ipu_entry_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .alloc     (req_fire),
        .alloc_pc  (fetch_pc),
        .fill      (fill),
        .fill_data (imem_rsp_data),
        .pop       (pop),
        .head      (head),
        .occupancy (occupancy),
        .unfilled  (unfilled)
    );

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Scoreboard bench for instruction_prefetch_unit with an in-order memory model.
module tb_instruction_prefetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
`ifdef IPU_BRANCH_ADDER_EN
    logic [31:0] redirect_base_pc = '0;
    logic [31:0] redirect_offset = '0;
`else
    logic [31:0] redirect_target = '0;
`endif
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [2:0]  occupancy;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int          n_req = 0;
    int          n_pop = 0;
    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] mem_addr_q[$];
    int unsigned mem_due_q[$];
    logic [31:0] sb_q[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];

    instruction_prefetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
`ifdef IPU_BRANCH_ADDER_EN
        .redirect_base_pc (redirect_base_pc),
        .redirect_offset  (redirect_offset),
`else
        .redirect_target  (redirect_target),
`endif
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .occupancy        (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] redir_dest();
`ifdef IPU_BRANCH_ADDER_EN
        return redirect_base_pc + redirect_offset;
`else
        return redirect_target;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Observe the handshakes that will complete at the coming rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb_q.delete();
            exp_addr = RESET_PC;
        end else begin
            if (redirect_valid) begin
                sb_q.delete();
                exp_addr = redir_dest();
            end else if (if_valid && if_ready) begin
                n_pop++;
                pop_log.push_back(if_pc);
                if (sb_q.size() == 0) begin
                    check_eq("pop_without_fetch", 32'(sb_q.size()), 32'd1);
                end else begin
                    logic [31:0] pc;
                    pc = sb_q.pop_front();
                    check_eq("if_pc", if_pc, pc);
                    check_eq("if_instr", if_instr, mem_word(pc));
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                check_eq("req_addr", imem_req_addr, exp_addr);
                req_log.push_back(imem_req_addr);
                mem_addr_q.push_back(imem_req_addr);
                mem_due_q.push_back(cyc + lat);
                sb_q.push_back(exp_addr);
                exp_addr = exp_addr + 32'd4;
                n_req++;
            end
        end
    end

    // Memory: in order, one response per cycle, at least lat cycles after the request.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            imem_rsp_valid = 1'b0;
            if (!reset_n) begin
                mem_addr_q.delete();
                mem_due_q.delete();
            end else if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        step(2);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] a, input logic [31:0] b);
`ifdef IPU_BRANCH_ADDER_EN
        redirect_base_pc = a;
        redirect_offset  = b;
`else
        redirect_target  = a + b;
`endif
        redirect_valid = 1'b1;
        step(1);
        redirect_valid = 1'b0;
        check_eq("redir_if_valid", 32'(if_valid), 32'd0);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) found = 1'b1;
        end
        if (found) check_eq(tag, imem_req_addr, exp);
        else check_eq({tag, "_timeout"}, 32'(found), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_if(input string tag, input logic [31:0] exp);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (if_valid) found = 1'b1;
        end
        if (found) check_eq(tag, if_pc, exp);
        else check_eq({tag, "_timeout"}, 32'(found), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r0;
        int p0;
        int viol;
        bit found;

        // Reset values while reset is held
        #12;
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_if_valid", 32'(if_valid), 32'd0);
        check_eq("rst_if_pc", if_pc, 32'd0);
        check_eq("rst_if_instr", if_instr, 32'd0);
        check_eq("rst_occupancy", 32'(occupancy), 32'd0);

        // Streaming with a 1-cycle memory
        lat = 1;
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        req_log.delete();
        pop_log.delete();
        release_reset();
        @(negedge clk);
        check_eq("a_first_req_valid", 32'(imem_req_valid), 32'd1);
        step(12);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("a_req%0d", i),
                     (i < req_log.size()) ? req_log[i] : 32'hFFFF_FFFF, 32'(i * 4));
        end
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("a_pop%0d", i),
                     (i < pop_log.size()) ? pop_log[i] : 32'hFFFF_FFFF, 32'(i * 4));
        end
        p0 = n_pop;
        step(10);
        check_eq("a_throughput", 32'(n_pop - p0), 32'd10);
        check_eq("a_steady_occ", 32'(occupancy), 32'd2);

        // Decode blocked: queue fills to DEPTH then requests stop
        apply_reset();
        if_ready = 1'b0;
        r0 = n_req;
        release_reset();
        step(10);
        check_eq("b_req_count", 32'(n_req - r0), 32'd4);
        check_eq("b_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("b_occupancy", 32'(occupancy), 32'd4);
        check_eq("b_head_pc", if_pc, 32'd0);
        if_ready = 1'b1;
        wait_req("b_resume_addr", 32'h10);

        // Redirect with two requests outstanding on a 3-cycle memory
        apply_reset();
        lat = 3;
        imem_req_ready = 1'b0;
        release_reset();
        step(1);
        r0 = n_req;
        imem_req_ready = 1'b1;
        step(2);
        imem_req_ready = 1'b0;
        check_eq("c_outstanding", 32'(n_req - r0), 32'd2);
        redirect_to(32'h100, 32'h0);
        imem_req_ready = 1'b1;
        viol = 0;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (mem_due_q.size() == 0 && !imem_rsp_valid) found = 1'b1;
            else if (imem_req_valid) viol++;
        end
        check_eq("c_drop_hold", 32'(viol), 32'd0);
        check_eq("c_drained", 32'(found), 32'd1);
        wait_if("c_first_pc", 32'h100);

        // Stall with the queue half full
        apply_reset();
        lat = 1;
        if_ready = 1'b0;
        imem_req_ready = 1'b0;
        release_reset();
        step(1);
        imem_req_ready = 1'b1;
        step(2);
        stall = 1'b1;
        if_ready = 1'b1;
        check_eq("d_half_full", 32'(occupancy), 32'd2);
        r0 = n_req;
        p0 = n_pop;
        step(3);
        check_eq("d_no_req", 32'(n_req - r0), 32'd0);
        check_eq("d_drain", 32'(n_pop - p0), 32'd2);
        check_eq("d_fetch_pc", imem_req_addr, 32'h8);
        check_eq("d_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("d_empty", 32'(occupancy), 32'd0);
        stall = 1'b0;
        wait_req("d_resume_addr", 32'h8);

        // Negative offset and address wrap
        step(3);
        redirect_to(32'h20, 32'hFFFF_FFF8);
        wait_req("e_adder_addr", 32'h18);
        step(2);
        redirect_to(32'h0, 32'hFFFF_FFFC);
        wait_req("e_wrap_hi", 32'hFFFF_FFFC);
        wait_req("e_wrap_zero", 32'h0);

        // Asynchronous reset during outstanding requests
        lat = 3;
        step(8);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("f_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("f_if_valid", 32'(if_valid), 32'd0);
        check_eq("f_if_pc", if_pc, 32'd0);
        check_eq("f_if_instr", if_instr, 32'd0);
        check_eq("f_occupancy", 32'(occupancy), 32'd0);
        step(2);
        release_reset();
        wait_req("f_restart_addr", RESET_PC);
        wait_if("f_restart_pc", RESET_PC);
        step(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch_unit.md
INSTRUCTION_PREFETCH_UNIT -- requirements
Module: instruction_prefetch_unit

Interface
REQ-001 Parameters SHALL be:
- XLEN, default 32, address/instruction width.
- DEPTH, default 4, queue entries; must be a power of 2 and at least 2.
- RESET_PC, default 0, fetch address after reset.
REQ-002 Ports SHALL be:
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  blocks new memory requests.
- redirect_valid  in  1  control-flow change this cycle.
- redirect_target  in  XLEN  new fetch address (only when IPU_BRANCH_ADDER_EN is undefined).
- redirect_base_pc  in  XLEN  branch/jump base (only when IPU_BRANCH_ADDER_EN is defined).
- redirect_offset  in  XLEN  signed immediate (only when IPU_BRANCH_ADDER_EN is defined).
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request address.
- imem_rsp_valid  in  1  in-order response, no earlier than 1 cycle after its request.
- imem_rsp_data  in  XLEN  instruction word.
- if_valid  out  1  head instruction available.
- if_ready  in  1  decode accepts head.
- if_instr  out  XLEN  head instruction.
- if_pc  out  XLEN  PC of head instruction.
- occupancy  out  log2(DEPTH)+1  allocated entries.

Function
REQ-003 fetch_pc register SHALL supply imem_req_addr; each request handshake (imem_req_valid && imem_req_ready) SHALL add 4 modulo 2^XLEN.
REQ-004 imem_req_valid SHALL be !stall && !redirect_valid && occupancy < DEPTH && drop_cnt == 0.
REQ-005 On request handshake, an entry SHALL be allocated at alloc pointer, tagged with the request PC, and marked unfilled.
REQ-006 A non-dropped response SHALL fill the oldest unfilled entry; responses are in order.
REQ-007 if_valid SHALL be 1 iff the head entry is filled; if_pc/if_instr SHALL come from the head, combinationally from the registered queue.
REQ-008 Pop SHALL occur on if_valid && if_ready; allocate, fill and pop in the same cycle SHALL all take effect, and a full queue popping SHALL NOT allow a same-cycle allocate (REQ-004 uses registered occupancy).
REQ-009 Redirect SHALL have priority over every other event:
- fetch_pc <= target;
- all entries are invalidated and pointers cleared;
- drop_cnt <= requests outstanding without response, excluding any response arriving that cycle, which is discarded;
- if_valid SHALL read 0 the following cycle.
REQ-010 While drop_cnt > 0, each imem_rsp_valid SHALL decrement drop_cnt and be discarded.
REQ-011 stall SHALL NOT block responses, pops or redirects.
REQ-012 First request after redirect SHALL be to target, one cycle later at the earliest; redirect-to-if_valid latency SHALL be at least 2 cycles plus memory latency.
REQ-013 Pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by occupancy.

Reset
REQ-014 Asserting reset_n low SHALL immediately set:
- fetch_pc=RESET_PC; pointers, occupancy and drop_cnt=0;
- all entries invalid; imem_req_valid=0; if_valid=0; if_pc=0; if_instr=0.
REQ-015 Reset mid-operation SHALL abandon in-flight requests; the memory is reset by the same reset_n.
REQ-016 First request SHALL issue in the first clock edge cycle after reset_n deasserts, when stall=0.

Configuration
REQ-017 Macro IPU_BRANCH_ADDER_EN:
- Defined: target = redirect_base_pc + redirect_offset (XLEN wrap); redirect_target is absent.
- Undefined: target = redirect_target; base/offset ports are absent.

Structure
REQ-018 Shared package ipu_pkg SHALL hold the entry struct {pc, instr, filled}, the occupancy width function, and the PC increment constant 4.
REQ-019 Queue storage SHALL be sub-module ipu_entry_queue (alloc/fill/pop pointers, occupancy); fetch_pc, drop_cnt and redirect control stay in the top level.

Verification
REQ-020 Reset, 1-cycle memory, if_ready=1 -> imem_req_addr 0,4,8,C; if_pc 0,4,8 in order; one instruction per cycle in steady state.
REQ-021 if_ready=0, DEPTH=4 -> exactly 4 requests, then imem_req_valid=0 and occupancy=4; if_ready=1 resumes with address 0x10.
REQ-022 Redirect to 0x100 with 2 requests outstanding -> next 2 responses discarded; imem_req_valid is held low until drop_cnt=0; first if_pc=0x100.
REQ-023 stall=1 for 3 cycles with queue half full -> no new requests; queued entries still drain; fetch_pc is unchanged.
REQ-024 IPU_BRANCH_ADDER_EN, base 0x20, offset 0xFFFFFFF8 -> next request address 0x18; fetch_pc 0xFFFFFFFC then increments to 0x0.
REQ-025 reset_n low during outstanding requests -> all outputs reach reset values without a clock edge; resumes at RESET_PC.
